// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
// Holds the FSM encoding, stage indices and control-bundle helpers.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        IREF = 2'd1,
        DREF = 2'd2,
        DIV  = 2'd3
    } state_e;

    localparam int STG_F = 0;
    localparam int STG_D = 1;
    localparam int STG_E = 2;
    localparam int STG_M = 3;
    localparam int STG_W = 4;

    typedef enum logic [1:0] {
        CNT_HOLD,
        CNT_LOAD,
        CNT_UP,
        CNT_DOWN
    } cnt_op_e;

    typedef struct packed {
        logic [STG_W:STG_F] en;
        logic [STG_W:STG_D] clr;
    } stage_ctl_t;

    function automatic stage_ctl_t ctl_run();
        stage_ctl_t c;
        c.en  = '1;
        c.clr = '0;
        return c;
    endfunction

    function automatic stage_ctl_t ctl_flush();
        stage_ctl_t c;
        c.en  = '1;
        c.clr = '1;
        return c;
    endfunction

    // Whole pipe frozen; W gets a bubble so the held M result is not written twice.
    function automatic stage_ctl_t ctl_mem_wait();
        stage_ctl_t c;
        c.en         = '0;
        c.clr        = '0;
        c.clr[STG_W] = 1'b1;
        return c;
    endfunction

    function automatic stage_ctl_t ctl_div();
        stage_ctl_t c;
        c.en         = '1;
        c.clr        = '0;
        c.en[STG_F]  = 1'b0;
        c.en[STG_D]  = 1'b0;
        c.en[STG_E]  = 1'b0;
        c.clr[STG_M] = 1'b1;
        return c;
    endfunction

    function automatic stage_ctl_t ctl_ifetch();
        stage_ctl_t c;
        c.en         = '1;
        c.clr        = '0;
        c.en[STG_F]  = 1'b0;
        c.clr[STG_D] = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Request/control bundle between the core datapath and the stall sequencer.
// master = datapath side, slave = controller side.
interface pipe_stall_ctrl_if;

    logic imiss_req;
    logic dmiss_req;
    logic refill_done;
    logic div_start_e;
    logic exception_m;
    logic load_use_d;
    logic branch_taken_d;

    logic en_f;
    logic en_d;
    logic en_e;
    logic en_m;
    logic en_w;
    logic clr_d;
    logic clr_e;
    logic clr_m;
    logic clr_w;
    logic refill_req;
    logic refill_sel;
    logic div_done;
    logic refill_timeout;

    modport master (
        output imiss_req, dmiss_req, refill_done, div_start_e,
        output exception_m, load_use_d, branch_taken_d,
        input  en_f, en_d, en_e, en_m, en_w,
        input  clr_d, clr_e, clr_m, clr_w,
        input  refill_req, refill_sel, div_done, refill_timeout
    );

    modport slave (
        input  imiss_req, dmiss_req, refill_done, div_start_e,
        input  exception_m, load_use_d, branch_taken_d,
        output en_f, en_d, en_e, en_m, en_w,
        output clr_d, clr_e, clr_m, clr_w,
        output refill_req, refill_sel, div_done, refill_timeout
    );

endinterface

// File: rtl/pipe_stall_ctrl_stall_cnt.sv
// Loadable saturating up/down counter shared by divide countdown and refill watchdog.
// Flags look at the next value so the owner can register pulses on time.
module stall_cnt
    import pipe_pkg::*;
#(
    parameter int CNT_W = 10,
    parameter int LIMIT = 1023
) (
    input  logic             clk,
    input  logic             rst_n,
    input  cnt_op_e          op_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o,
    output logic             nxt_zero_o,
    output logic             nxt_lim_o
);

    localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        unique case (op_i)
            CNT_LOAD: cnt_d = load_val_i;
            CNT_UP:   if (cnt_q != LIM) cnt_d = cnt_q + ONE;
            CNT_DOWN: if (cnt_q != '0) cnt_d = cnt_q - ONE;
            default:  cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o     = (cnt_q == '0);
    assign nxt_zero_o = (cnt_d == '0);
    assign nxt_lim_o  = (cnt_d == LIM);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush sequencer: refill arbitration, divide freeze,
// exception and hazard flushes for the F/D/E/M/W registers.
module pipe_stall_ctrl
    import pipe_pkg::*;
#(
    parameter int DIV_CYCLES = 32,
    parameter int TIMEOUT    = 1023,
    parameter int CNT_W      = 10
) (
    input  logic             clk,
    input  logic             resetn,
    pipe_stall_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_CYCLES - 1);

    state_e           state_q;
    state_e           state_d;
    cnt_op_e          op;
    logic [CNT_W-1:0] ld_val;
    stage_ctl_t       ctl;
    stage_ctl_t       ctl_o;
    logic             req;
    logic             sel;
    logic             cnt_zero;
    logic             nxt_zero;
    logic             nxt_lim;
    logic             timeout_q;
    logic             timeout_d;
    logic             div_done_q;
    logic             div_done_d;

    stall_cnt #(
        .CNT_W (CNT_W),
        .LIMIT (TIMEOUT)
    ) u_cnt (
        .clk        (clk),
        .rst_n      (resetn),
        .op_i       (op),
        .load_val_i (ld_val),
        .zero_o     (cnt_zero),
        .nxt_zero_o (nxt_zero),
        .nxt_lim_o  (nxt_lim)
    );

    always_comb begin
        state_d = state_q;
        op      = CNT_HOLD;
        ld_val  = '0;
        ctl     = ctl_run();
        req     = 1'b0;
        sel     = 1'b0;
        unique case (state_q)
            RUN: begin
                if (bus.exception_m) begin
                    ctl = ctl_flush();
                end else if (bus.dmiss_req) begin
                    state_d = DREF;
                    op      = CNT_LOAD;
                    ctl     = ctl_mem_wait();
                end else if (bus.div_start_e) begin
                    state_d = DIV;
                    op      = CNT_LOAD;
                    ld_val  = DIV_LD;
                    ctl     = ctl_div();
                end else if (bus.imiss_req) begin
                    state_d = IREF;
                    op      = CNT_LOAD;
                    ctl     = ctl_ifetch();
                end else if (bus.load_use_d) begin
                    ctl.en[STG_F]  = 1'b0;
                    ctl.en[STG_D]  = 1'b0;
                    ctl.clr[STG_E] = 1'b1;
                end else if (bus.branch_taken_d) begin
                    ctl.clr[STG_D] = 1'b1;
                end
            end
            IREF: begin
                req = 1'b1;
                op  = CNT_UP;
                // Refill is non-preemptive: a D-miss waits for the I-block.
                ctl = bus.dmiss_req ? ctl_mem_wait() : ctl_ifetch();
                if (bus.refill_done) begin
                    if (bus.dmiss_req) begin
                        state_d = DREF;
                        op      = CNT_LOAD;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            DREF: begin
                req = 1'b1;
                sel = 1'b1;
                op  = CNT_UP;
                ctl = ctl_mem_wait();
                if (bus.refill_done) state_d = RUN;
            end
            DIV: begin
                if (bus.exception_m) begin
                    state_d = RUN;
                    op      = CNT_LOAD;
                    ctl     = ctl_flush();
                end else begin
                    ctl = ctl_div();
                    if (cnt_zero) state_d = RUN;
                    else op = CNT_DOWN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign timeout_d = timeout_q
                     | ((state_q == IREF || state_q == DREF)
                        && op == CNT_UP && nxt_lim);
    assign div_done_d = (state_d == DIV) && nxt_zero;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= RUN;
            timeout_q  <= 1'b0;
            div_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timeout_q  <= timeout_d;
            div_done_q <= div_done_d;
        end
    end

    // Hold the pipe at defaults while reset is asserted.
    assign ctl_o = resetn ? ctl : ctl_run();

    assign bus.en_f           = ctl_o.en[STG_F];
    assign bus.en_d           = ctl_o.en[STG_D];
    assign bus.en_e           = ctl_o.en[STG_E];
    assign bus.en_m           = ctl_o.en[STG_M];
    assign bus.en_w           = ctl_o.en[STG_W];
    assign bus.clr_d          = ctl_o.clr[STG_D];
    assign bus.clr_e          = ctl_o.clr[STG_E];
    assign bus.clr_m          = ctl_o.clr[STG_M];
    assign bus.clr_w          = ctl_o.clr[STG_W];
    assign bus.refill_req     = resetn & req;
    assign bus.refill_sel     = resetn & sel;
    assign bus.div_done       = div_done_q;
    assign bus.refill_timeout = timeout_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed scenarios plus random traffic,
// every cycle compared against a cycle-count reference model.
module tb_pipe_stall_ctrl;

    localparam int DIVC = 32;
    localparam int TMO  = 15;
    localparam int CW   = 10;

    localparam int S_RUN  = 0;
    localparam int S_IREF = 1;
    localparam int S_DREF = 2;
    localparam int S_DIV  = 3;

    logic clk    = 1'b0;
    logic resetn = 1'b0;

    pipe_stall_ctrl_if bus();

    pipe_stall_ctrl #(
        .DIV_CYCLES (DIVC),
        .TIMEOUT    (TMO),
        .CNT_W      (CW)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    // Model: phase, cycles spent in current refill, divide cycle index, sticky timeout.
    int m_st   = S_RUN;
    int m_k    = 0;
    int m_divn = 0;
    bit m_to   = 1'b0;

    logic [12:0] exp_v;
    logic [12:0] obs;

    assign obs = {bus.en_f, bus.en_d, bus.en_e, bus.en_m, bus.en_w,
                  bus.clr_d, bus.clr_e, bus.clr_m, bus.clr_w,
                  bus.refill_req, bus.refill_sel,
                  bus.div_done, bus.refill_timeout};

    function automatic logic [12:0] m_out();
        logic [4:0] en;
        logic [3:0] clr;
        logic       rq;
        logic       sl;
        logic       dd;
        en  = 5'b11111;
        clr = 4'b0000;
        rq  = 1'b0;
        sl  = 1'b0;
        dd  = (m_st == S_DIV) && (m_divn == DIVC);
        if (!resetn) return {en, clr, rq, sl, 1'b0, 1'b0};
        case (m_st)
            S_RUN: begin
                if (bus.exception_m) clr = 4'b1111;
                else if (bus.dmiss_req) begin en = 5'b00000; clr = 4'b0001; end
                else if (bus.div_start_e) begin en = 5'b00011; clr = 4'b0010; end
                else if (bus.imiss_req) begin en = 5'b01111; clr = 4'b1000; end
                else if (bus.load_use_d) begin en = 5'b00111; clr = 4'b0100; end
                else if (bus.branch_taken_d) clr = 4'b1000;
            end
            S_IREF: begin
                rq = 1'b1;
                if (bus.dmiss_req) begin en = 5'b00000; clr = 4'b0001; end
                else begin en = 5'b01111; clr = 4'b1000; end
            end
            S_DREF: begin
                rq  = 1'b1;
                sl  = 1'b1;
                en  = 5'b00000;
                clr = 4'b0001;
            end
            default: begin
                if (bus.exception_m) clr = 4'b1111;
                else begin en = 5'b00011; clr = 4'b0010; end
            end
        endcase
        return {en, clr, rq, sl, dd, m_to};
    endfunction

    task automatic m_reset();
        m_st   = S_RUN;
        m_k    = 0;
        m_divn = 0;
        m_to   = 1'b0;
    endtask

    task automatic cyc(input logic im, input logic dm, input logic dn,
                       input logic dv, input logic ex, input logic lu,
                       input logic br, input logic rn);
        bus.imiss_req      = im;
        bus.dmiss_req      = dm;
        bus.refill_done    = dn;
        bus.div_start_e    = dv;
        bus.exception_m    = ex;
        bus.load_use_d     = lu;
        bus.branch_taken_d = br;
        resetn             = rn;
        if (!rn) m_reset();
        #1;
        exp_v = m_out();
    endtask

    task automatic tick();
        int ns;
        int nk;
        int nd;
        bit nt;
        ns = m_st;
        nk = m_k;
        nd = m_divn;
        nt = m_to;
        if (resetn) begin
            case (m_st)
                S_RUN: begin
                    if (bus.exception_m) ns = S_RUN;
                    else if (bus.dmiss_req) begin ns = S_DREF; nk = 1; end
                    else if (bus.div_start_e) begin ns = S_DIV; nd = 1; end
                    else if (bus.imiss_req) begin ns = S_IREF; nk = 1; end
                end
                S_IREF: begin
                    if (bus.refill_done && bus.dmiss_req) begin
                        ns = S_DREF;
                        nk = 1;
                    end else begin
                        if (m_k >= TMO) nt = 1'b1;
                        if (bus.refill_done) ns = S_RUN;
                        else nk = m_k + 1;
                    end
                end
                S_DREF: begin
                    if (m_k >= TMO) nt = 1'b1;
                    if (bus.refill_done) ns = S_RUN;
                    else nk = m_k + 1;
                end
                default: begin
                    if (bus.exception_m || m_divn == DIVC) ns = S_RUN;
                    else nd = m_divn + 1;
                end
            endcase
        end
        @(posedge clk);
        m_st   = ns;
        m_k    = nk;
        m_divn = nd;
        m_to   = nt;
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            if (i < 2) cyc(1, 1, 0, 1, 1, 1, 1, 0);
            else cyc(0, 0, 0, 0, 0, 0, 0, 1);
            checks++;
            if (obs !== exp_v) begin
                errs++;
                $display("FAIL reset i=%0d got=%b exp=%b", i, obs, exp_v);
            end
            tick();
        end
    endtask

    task automatic test_imiss();
        for (int i = 0; i < 12; i++) begin
            cyc(i < 9, 0, i == 8, 0, 0, 0, 0, 1);
            checks++;
            if (obs !== exp_v) begin
                errs++;
                $display("FAIL imiss i=%0d got=%b exp=%b", i, obs, exp_v);
            end
            tick();
        end
    endtask

    task automatic test_both_miss();
        for (int i = 0; i < 13; i++) begin
            cyc(i <= 10, i <= 5, i == 5 || i == 10, 0, 0, 0, 0, 1);
            checks++;
            if (obs !== exp_v) begin
                errs++;
                $display("FAIL both_miss i=%0d got=%b exp=%b", i, obs, exp_v);
            end
            tick();
        end
    endtask

    task automatic test_div();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 36; i++) begin
            cyc(0, 0, i == 4, i <= 32, 0, 0, 0, 1);
            if (bus.div_done === 1'b1) pulses++;
            checks++;
            if (obs !== exp_v) begin
                errs++;
                $display("FAIL div i=%0d got=%b exp=%b", i, obs, exp_v);
            end
            tick();
        end
        checks++;
        if (pulses !== 1) begin
            errs++;
            $display("FAIL div_pulses got=%0d exp=1", pulses);
        end
    endtask

    task automatic test_div_abort();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 14; i++) begin
            cyc(0, 0, 0, i <= 10, i == 10, 0, 0, 1);
            if (bus.div_done === 1'b1) pulses++;
            checks++;
            if (obs !== exp_v) begin
                errs++;
                $display("FAIL div_abort i=%0d got=%b exp=%b", i, obs, exp_v);
            end
            tick();
        end
        checks++;
        if (pulses !== 0) begin
            errs++;
            $display("FAIL abort_pulses got=%0d exp=0", pulses);
        end
    endtask

    task automatic test_hazard();
        logic [2:0] tbl [5];
        tbl = '{3'b011, 3'b010, 3'b001, 3'b111, 3'b000};
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0, tbl[i][2], tbl[i][1], tbl[i][0], 1);
            checks++;
            if (obs !== exp_v) begin
                errs++;
                $display("FAIL hazard i=%0d got=%b exp=%b", i, obs, exp_v);
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(3) == 0, $urandom_range(5) == 0,
                $urandom_range(3) == 0, $urandom_range(7) == 0,
                $urandom_range(15) == 0, $urandom_range(4) == 0,
                $urandom_range(4) == 0, 1);
            checks++;
            if (obs !== exp_v) begin
                errs++;
                $display("FAIL random i=%0d got=%b exp=%b", i, obs, exp_v);
            end
            tick();
        end
    endtask

    task automatic test_timeout();
        // Clean slate so the sticky flag starts low.
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 30; i++) begin
            cyc(0, i <= 21 || i >= 26, i == 21, 0, 0, 0, 0, i != 28);
            checks++;
            if (obs !== exp_v) begin
                errs++;
                $display("FAIL timeout i=%0d got=%b exp=%b", i, obs, exp_v);
            end
            if (i == 28) begin
                checks++;
                if (bus.refill_req !== 1'b0) begin
                    errs++;
                    $display("FAIL reset_req got=%b exp=0", bus.refill_req);
                end
            end
            tick();
        end
    endtask

    initial begin
        bus.imiss_req      = 1'b0;
        bus.dmiss_req      = 1'b0;
        bus.refill_done    = 1'b0;
        bus.div_start_e    = 1'b0;
        bus.exception_m    = 1'b0;
        bus.load_use_d     = 1'b0;
        bus.branch_taken_d = 1'b0;
        @(negedge clk);
        test_reset();
        test_imiss();
        test_both_miss();
        test_div();
        test_div_abort();
        test_hazard();
        test_random();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central sequencer for the enable/clear inputs of the five pipeline registers (F, D, E, M, W) in the multi-word-block cached MIPS core.
- Arbitrates the single shared cache-refill port between I-cache and D-cache misses.
- Freezes the pipeline for multi-cycle divides.
- Flushes the pipeline on exceptions, load-use hazards and taken branches.

Parameters:
DIV_CYCLES, 32, cycles E is held for a divide (>=2)
TIMEOUT, 1023, refill watchdog limit in cycles
CNT_W, 10, width of the shared cycle counter (must hold max(DIV_CYCLES, TIMEOUT))

Ports:
clk  in  1  core clock
resetn  in  1  asynchronous reset, active-low
imiss_req  in  1  I-cache miss in F (level, held until serviced)
dmiss_req  in  1  D-cache miss in M (level)
refill_done  in  1  one-cycle pulse: shared refill port finished current block
div_start_e  in  1  divide instruction in E (level)
exception_m  in  1  exception committed in M
load_use_d  in  1  load-use hazard detected in D
branch_taken_d  in  1  branch/jump redirect resolved in D
en_f, en_d, en_e, en_m, en_w  out  1 each  register enables
clr_d, clr_e, clr_m, clr_w  out  1 each  register synchronous clears (bubble)
refill_req  out  1  request on shared refill port
refill_sel  out  1  0 = I-cache owns refill, 1 = D-cache
div_done  out  1  one-cycle pulse: divide result valid in E
refill_timeout  out  1  sticky watchdog error

Behaviour:
- Registered state: RUN, IREF, DREF, DIV. Also registered: CNT_W counter, refill_timeout, div_done.
- Async reset state: RUN, counter 0, refill_timeout 0, div_done 0.
- Enables, clears, refill_req and refill_sel are combinational from state and inputs.
- Values seen during reset: all en=1, all clr=0, refill_req=0.

RUN decision priority, highest first (evaluated each cycle):
1. exception_m: en all 1; clr_d=clr_e=clr_m=clr_w=1; stay RUN.
2. dmiss_req: next DREF, counter<=0; this cycle en all 0, clr_w=1.
3. div_start_e: next DIV, counter<=DIV_CYCLES-1; en_f=en_d=en_e=0, clr_m=1.
4. imiss_req: next IREF, counter<=0; en_f=0, clr_d=1.
5. load_use_d: en_f=en_d=0, clr_e=1.
6. branch_taken_d: clr_d=1.
7. Otherwise: all en=1, all clr=0.

IREF:
- refill_req=1, refill_sel=0.
- en_f=0, clr_d=1; E/M/W run.
- If dmiss_req is also high: en all 0, clr_w=1. The refill is non-preemptive, so M waits.
- On refill_done: next DREF if dmiss_req, else RUN.

DREF:
- refill_req=1, refill_sel=1.
- en all 0, clr_w=1 (no duplicate writeback).
- On refill_done: next RUN.
- An I-miss still pending is re-sampled in RUN.

DIV:
- en_f=en_d=en_e=0, clr_m=1; counter decrements each cycle.
- At counter==0: div_done=1 for that cycle; next RUN.
- exception_m in DIV: abort. Apply the RUN exception outputs, counter<=0, next RUN, no div_done.

Exception handling during refills:
- exception_m is ignored in IREF/DREF; refills are never aborted.
- M-stage inputs are held while frozen, so the exception reappears in RUN.

Watchdog:
- In IREF/DREF the counter increments.
- When it reaches TIMEOUT, set refill_timeout (sticky until reset). State still waits for refill_done.

Simultaneous events:
- refill_done arriving while in RUN or DIV is ignored.
- Divide and D-miss together: D-miss is serviced first. div_start_e stays high because E is frozen, so the divide starts afterwards.

Reset mid-operation: an immediate return to RUN with all defaults; any outstanding refill_req drops at once.

Decomposition:
- Shared package pipe_pkg holds the state encoding constants (RUN=2'd0, IREF=2'd1, DREF=2'd2, DIV=2'd3) and stage index constants.
- One natural sub-module, stall_cnt: loadable up/down counter with zero and limit flags, used for both the divide countdown and the watchdog.
- The controller's outputs feed the existing flopenrc pipeline registers directly.

Test Plan:
- Reset, then idle for 3 cycles -> all en=1, all clr=0, refill_req=0.
- Pulse imiss_req, then refill_done 8 cycles later -> 8 cycles of en_f=0, clr_d=1, refill_sel=0; RUN on cycle 9.
- Assert imiss_req and dmiss_req together -> DREF first (refill_sel=1, all en=0, clr_w=1); after refill_done -> IREF, then RUN.
- div_start_e with DIV_CYCLES=32 -> en_e=0 for 32 cycles; div_done pulses on the 32nd; exception_m at cycle 10 instead -> immediate flush, no div_done.
- load_use_d and branch_taken_d in the same RUN cycle -> en_f=en_d=0, clr_e=1, clr_d=0.
- TIMEOUT=15, no refill_done -> refill_timeout=1 after 15 DREF cycles and stays high until resetn=0 (reset mid-DREF -> refill_req=0 immediately).
